// File: rtl/wave_display.sv
// -----------------------------------------------------------------------------
// wave_display
//
// Purpose:
//   Renders the 256-sample waveform held in a two-page sample RAM as pixels
//   for a 1280x720 scan. Scan coordinates are turned into RAM read addresses.
//   A connected trace is drawn by lighting, in each sample's two-pixel-wide
//   column, the vertical span between the previous and the current sample.
//   The colour of each pixel appears exactly two cycles after its coordinates.
//
//   The wave window is 256 <= x <= 767, y <= 511. Each sample covers two
//   pixel columns and each display row covers two scan lines. A sample value
//   v is drawn on display row 255 - v, so larger values appear higher.
//
// Optional feature:
//   WAVE_DISPLAY_GRID_EN - when defined, in-window pixels that are not lit
//   get GRID_COLOR on the centre axis (row 128) and on a vertical tick every
//   32 samples. Without it, non-lit pixels are black and no grid logic
//   exists.
//
// Parameters:
//   LINE_COLOR  {r,g,b} of lit trace pixels
//   GRID_COLOR  {r,g,b} of grid pixels (used only with WAVE_DISPLAY_GRID_EN)
//
// Ports:
//   clk                in   system clock
//   reset              in   synchronous, active-high reset
//   x                  in   scan column, 0..1279
//   y                  in   scan row, 0..719
//   valid              in   x/y describe a visible pixel this cycle
//   read_index         in   RAM page released by the capture stage
//   read_address       out  combinational RAM address {page, sample index}
//   read_value         in   RAM data, one cycle after read_address
//   valid_pixel        out  r/g/b valid (valid delayed by two cycles)
//   r, g, b            out  pixel colour
//   wave_display_idle  out  registered (y >= 512): page swap is safe
// -----------------------------------------------------------------------------
module wave_display #(
    parameter logic [23:0] LINE_COLOR = 24'hFFFFFF,
    parameter logic [23:0] GRID_COLOR = 24'h404040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    output logic [8:0]  read_address,
    input  logic [7:0]  read_value,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    localparam logic [10:0] WIN_X_LO  = 11'd256;
    localparam logic [10:0] WIN_X_HI  = 11'd767;
    localparam logic [9:0]  WAVE_Y_HI = 10'd511;

    // -------------------------------------------------------------------------
    // Stage 0: address generation from the incoming scan position
    // -------------------------------------------------------------------------
    logic       in_win_s0;
    logic       below_wave_s0;   // scan is in rows 512 and up
    logic [7:0] sidx_s0;

    logic       frame_index_q, frame_index_d;

    always_comb begin
        in_win_s0     = (x >= WIN_X_LO) && (x <= WIN_X_HI) && (y <= WAVE_Y_HI);
        below_wave_s0 = (y > WAVE_Y_HI);
        // Outside the window the RAM is still read at x[8:1]. Nothing
        // downstream uses that data for colour, but it keeps the address path
        // free of extra muxing on the window edge.
        if (in_win_s0) begin
            sidx_s0 = 8'((x - WIN_X_LO) >> 1);
        end else begin
            sidx_s0 = x[8:1];
        end
    end

    assign read_address = {frame_index_q, sidx_s0};

    // The page only follows read_index while the scan is below the wave rows,
    // so a whole frame's wave region is drawn from one page.
    assign frame_index_d = below_wave_s0 ? read_index : frame_index_q;

    // -------------------------------------------------------------------------
    // Stage 0 -> 1 pipeline registers
    // -------------------------------------------------------------------------
    logic       valid_s1_q,  valid_s1_d;
    logic       in_win_s1_q, in_win_s1_d;
    logic [7:0] row_s1_q,    row_s1_d;
    logic [7:0] sidx_s1_q,   sidx_s1_d;
    logic       idle_q,      idle_d;

    always_comb begin
        valid_s1_d  = valid;
        in_win_s1_d = in_win_s0;
        row_s1_d    = y[8:1];
        sidx_s1_d   = sidx_s0;
        idle_d      = below_wave_s0;
    end

    // -------------------------------------------------------------------------
    // Optional grid: flag computed in stage 0, used in stage 1
    // -------------------------------------------------------------------------
    logic grid_hit_s1;

`ifdef WAVE_DISPLAY_GRID_EN
    logic grid_s1_q, grid_s1_d;

    // (x - 256)[5:0] equals x[5:0] because 256 has no bits below bit 8.
    assign grid_s1_d = (y[8:1] == 8'd128) || (x[5:0] == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_s1_q <= 1'b0;
        end else begin
            grid_s1_q <= grid_s1_d;
        end
    end

    assign grid_hit_s1 = grid_s1_q;
`else
    assign grid_hit_s1 = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Stage 1: sample history and lit decision
    // -------------------------------------------------------------------------
    logic [7:0]  cur_q,       cur_d;        // read_value seen last stage-1 cycle
    logic [7:0]  prev_reg_q,  prev_reg_d;   // value of the previous sample
    logic [7:0]  last_sidx_q, last_sidx_d;  // sample index seen last stage-1 cycle

    logic        idx_changed_s1;
    logic [7:0]  prev_s1;
    logic [7:0]  span_hi_val, span_lo_val;
    logic [7:0]  span_top, span_bot;
    logic        lit_s1;
    logic        draw_s1;

    logic [23:0] rgb_q,         rgb_d;
    logic        valid_pixel_q, valid_pixel_d;

    // NOTE: every signal in a combinational block is given a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        cur_d       = read_value;
        last_sidx_d = sidx_s1_q;

        // On the first pixel of a new sample the old "current" value becomes
        // the previous one. It is forwarded straight into this cycle's span so
        // that no pixel of the new sample sees a stale prev.
        idx_changed_s1 = (sidx_s1_q != last_sidx_q);
        prev_reg_d     = idx_changed_s1 ? cur_q : prev_reg_q;

        // Sample 0 starts a fresh trace: no line back to the previous row.
        if (sidx_s1_q == 8'd0) begin
            prev_s1 = read_value;
        end else begin
            prev_s1 = prev_reg_d;
        end

        if (prev_s1 > read_value) begin
            span_hi_val = prev_s1;
            span_lo_val = read_value;
        end else begin
            span_hi_val = read_value;
            span_lo_val = prev_s1;
        end

        // 255 - v on 8 bits never underflows.
        span_top = 8'd255 - span_hi_val;
        span_bot = 8'd255 - span_lo_val;

        draw_s1 = valid_s1_q && in_win_s1_q;
        lit_s1  = draw_s1 && (row_s1_q >= span_top) && (row_s1_q <= span_bot);

        valid_pixel_d = valid_s1_q;
        rgb_d         = 24'h000000;
        if (lit_s1) begin
            rgb_d = LINE_COLOR;
        end else if (draw_s1 && grid_hit_s1) begin
            rgb_d = GRID_COLOR;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_index_q <= 1'b0;
            valid_s1_q    <= 1'b0;
            in_win_s1_q   <= 1'b0;
            row_s1_q      <= 8'd0;
            sidx_s1_q     <= 8'd0;
            idle_q        <= 1'b0;
            cur_q         <= 8'd0;
            prev_reg_q    <= 8'd0;
            last_sidx_q   <= 8'd0;
            rgb_q         <= 24'h000000;
            valid_pixel_q <= 1'b0;
        end else begin
            frame_index_q <= frame_index_d;
            valid_s1_q    <= valid_s1_d;
            in_win_s1_q   <= in_win_s1_d;
            row_s1_q      <= row_s1_d;
            sidx_s1_q     <= sidx_s1_d;
            idle_q        <= idle_d;
            cur_q         <= cur_d;
            prev_reg_q    <= prev_reg_d;
            last_sidx_q   <= last_sidx_d;
            rgb_q         <= rgb_d;
            valid_pixel_q <= valid_pixel_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_pixel       = valid_pixel_q;
    assign r                 = rgb_q[23:16];
    assign g                 = rgb_q[15:8];
    assign b                 = rgb_q[7:0];
    assign wave_display_idle = idle_q;

endmodule

// File: tb/tb_wave_display.sv
// -----------------------------------------------------------------------------
// tb_wave_display
//
// Drives raster-ordered scan lines into wave_display, with a two-page sample
// RAM modelled here. Each pixel's expected colour comes from a reference
// function that applies the drawing rules directly to the RAM contents: the
// column gives sample i, the previous sample is i-1 (or i itself for i = 0),
// and the row is lit if it lies between the two values' display rows.
// Expected pixels travel through a two-entry queue that matches the
// pipeline latency.
// -----------------------------------------------------------------------------
module tb_wave_display;

    localparam logic [23:0] LINE_RGB = 24'hFFFFFF;
    localparam logic [23:0] GRID_RGB = 24'h404040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        valid = 1'b0;
    logic        read_index = 1'b0;
    logic [8:0]  read_address;
    logic [7:0]  read_value = '0;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    wave_display dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    // Two-page sample RAM with one cycle of read latency.
    logic [7:0] ram [2][256];
    always @(posedge clk) read_value <= ram[read_address[8]][read_address[7:0]];

    typedef struct packed {
        int          xi;
        int          yi;
        logic        vp;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   model_page = 1'b0;   // page the design should be reading from
    bit   exp_idle = 1'b0;
    bit   armed = 1'b0;
    bit   cur_ri = 1'b0;

    // Reference colour of one pixel, straight from the drawing rules.
    function automatic exp_t model_pixel(input int xi, input int yi, input bit vi, input bit pg);
        exp_t e;
        int   i, c, p, row, top, bot;
        e.xi  = xi;
        e.yi  = yi;
        e.vp  = vi;
        e.rgb = 24'h000000;
        if (vi && xi >= 256 && xi <= 767 && yi <= 511) begin
            i   = (xi - 256) / 2;
            c   = int'(ram[pg][i]);
            p   = (i == 0) ? c : int'(ram[pg][i - 1]);
            row = yi / 2;
            top = 255 - ((c > p) ? c : p);
            bot = 255 - ((c < p) ? c : p);
            if (row >= top && row <= bot) e.rgb = LINE_RGB;
`ifdef WAVE_DISPLAY_GRID_EN
            else if (row == 128 || ((xi - 256) % 64) == 0) e.rgb = GRID_RGB;
`endif
        end
        return e;
    endfunction

    // One scan cycle: check outputs due now, apply new inputs, check the
    // combinational address, and queue this pixel's expected result.
    task automatic drive(input int xi, input int yi, input bit vi, input bit ri, input bit rst);
        exp_t e;
        int   sidx;
        @(negedge clk);
        if (armed) begin
            n_cmp++;
            if (wave_display_idle !== exp_idle) begin
                n_bad++;
                $display("FAIL idle: got %b expected %b", wave_display_idle, exp_idle);
            end
        end
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({valid_pixel, r, g, b} !== {e.vp, e.rgb}) begin
                n_bad++;
                $display("FAIL pixel x=%0d y=%0d: got vp=%b rgb=%h expected vp=%b rgb=%h",
                         e.xi, e.yi, valid_pixel, {r, g, b}, e.vp, e.rgb);
            end
        end
        x          = 11'(xi);
        y          = 10'(yi);
        valid      = vi;
        read_index = ri;
        reset      = rst;
        if (rst) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                exp_q[k].vp  = 1'b0;
                exp_q[k].rgb = 24'h000000;
            end
        end
        sidx = (xi >= 256 && xi <= 767 && yi <= 511) ? (xi - 256) / 2 : (xi / 2) % 256;
        #1;
        n_cmp++;
        if (read_address !== {model_page, 8'(sidx)}) begin
            n_bad++;
            $display("FAIL read_address x=%0d y=%0d: got %h expected %h",
                     xi, yi, read_address, {model_page, 8'(sidx)});
        end
        if (rst) begin
            e.xi = xi; e.yi = yi; e.vp = 1'b0; e.rgb = 24'h000000;
        end else begin
            e = model_pixel(xi, yi, vi, model_page);
        end
        exp_q.push_back(e);
        model_page = rst ? 1'b0 : ((yi >= 512) ? ri : model_page);
        exp_idle   = rst ? 1'b0 : (yi >= 512);
        armed      = 1'b1;
    endtask

    task automatic scan_row(input int yi, input int x0, input int x1, input bit rand_valid);
        for (int xi = x0; xi <= x1; xi++)
            drive(xi, yi, rand_valid ? ($urandom_range(3) != 0) : 1'b1, cur_ri, 1'b0);
    endtask

    // Drains the pipeline with blank pixels so the RAM can be rewritten.
    task automatic flush();
        for (int k = 0; k < 3; k++) drive(0, 0, 1'b0, cur_ri, 1'b0);
    endtask

    task automatic fill_page(input bit pg, input int mode, input logic [7:0] value);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       ram[pg][i] = value;
                1:       ram[pg][i] = 8'(i);
                default: ram[pg][i] = 8'($urandom_range(255));
            endcase
        end
    endtask

    task automatic test_reset();
        fill_page(0, 0, 8'h02);   // trace on display row 253: y = 506, 507
        fill_page(1, 0, 8'h02);
        for (int k = 0; k < 4; k++) drive(0, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({valid_pixel, r, g, b, wave_display_idle} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_state: got vp=%b rgb=%h idle=%b expected all zero",
                     valid_pixel, {r, g, b}, wave_display_idle);
        end
        scan_row(506, 240, 420, 1'b0);
        drive(421, 506, 1'b1, 1'b0, 1'b1);
        drive(422, 506, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({valid_pixel, r, g, b} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_midline: got vp=%b rgb=%h expected 0/000000",
                     valid_pixel, {r, g, b});
        end
        scan_row(506, 240, 600, 1'b0);
    endtask

    task automatic test_flat();
        int rows[7] = '{0, 100, 253, 254, 255, 256, 511};
        flush();
        fill_page(0, 0, 8'h80);
        foreach (rows[k]) scan_row(rows[k], 248, 776, 1'b0);
    endtask

    task automatic test_ramp();
        int rows[7] = '{508, 509, 510, 511, 254, 257, 0};
        flush();
        fill_page(0, 1, 8'h00);
        foreach (rows[k]) scan_row(rows[k], 248, 776, 1'b0);
    endtask

    task automatic test_page_select();
        flush();
        fill_page(0, 2, 8'h00);
        fill_page(1, 2, 8'h00);
        cur_ri = 1'b1;               // released while scan is in the wave rows
        scan_row(100, 240, 780, 1'b0);
        n_cmp++;
        if (read_address[8] !== 1'b0) begin
            n_bad++;
            $display("FAIL page_hold: got %b expected 0", read_address[8]);
        end
        drive(0, 512, 1'b0, cur_ri, 1'b0);
        drive(0, 512, 1'b0, cur_ri, 1'b0);
        n_cmp++;
        if (read_address[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL page_swap: got %b expected 1", read_address[8]);
        end
        scan_row(2 * (255 - int'(ram[1][40])), 240, 780, 1'b0);
        scan_row(400, 240, 780, 1'b1);
        cur_ri = 1'b0;
        drive(0, 600, 1'b0, cur_ri, 1'b0);
        flush();
    endtask

    task automatic test_idle_sweep();
        for (int yi = 508; yi <= 719; yi++) begin
            drive(1000, yi, 1'b0, cur_ri, 1'b0);
            if (yi == 512) begin
                n_cmp++;
                if (wave_display_idle !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_early: got %b expected 0", wave_display_idle);
                end
            end
        end
        for (int yi = 0; yi < 4; yi++) drive(1000, yi, 1'b1, cur_ri, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            flush();
            fill_page(0, 2, 8'h00);
            for (int k = 0; k < 8; k++) begin
                int i  = $urandom_range(255);
                int yi = 2 * (255 - int'(ram[0][i])) + int'($urandom_range(1));
                scan_row(yi, $urandom_range(255, 200), $urandom_range(800, 760), 1'b1);
            end
        end
    endtask

    task automatic test_grid();
        int rows[5] = '{256, 257, 510, 100, 511};
        flush();
        fill_page(0, 0, 8'h00);
        foreach (rows[k]) scan_row(rows[k], 248, 776, 1'b0);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_page_select();
        test_idle_sweep();
        test_random();
        test_grid();
        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
